tl_cntr_nway: RTL and testbench

Parametrised N-approach traffic light controller. It generalises the two-road Ta/Tb controller to N_DIR approaches with round-robin service, minimum and maximum green timers, timed yellow and all-red phases, and a night flash mode. Lights are Moore outputs decoded from registered state. It sits at the intersection top level, between the sensor inputs and the lamp drivers.

---
 rtl/tl_cntr_nway.sv | 164 ++++++++++++++++
 tb/tb_tl_cntr_nway.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/tl_cntr_nway.sv
// N-approach traffic light controller: round-robin green service with min/max
// green, timed yellow and all-red clearance, and a night flash mode.
module tl_cntr_nway #(
  parameter int N_DIR      = 4,
  parameter int GREEN_MIN  = 4,
  parameter int GREEN_MAX  = 10,
  parameter int YELLOW_CYC = 2,
  parameter int ALLRED_CYC = 1,
  parameter int FLASH_HALF = 3,
  parameter int CNT_W      = 8,
  parameter int DIR_W      = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N_DIR-1:0]     T,
  input  logic                 flash_en,
  output logic [2*N_DIR-1:0]   L,
  output logic [DIR_W-1:0]     cur_dir,
  output logic [1:0]           phase
);

  typedef enum logic [1:0] {
    PH_GREEN  = 2'b00,
    PH_YELLOW = 2'b01,
    PH_ALLRED = 2'b10,
    PH_FLASH  = 2'b11
  } phase_t;

  localparam logic [1:0] LAMP_GREEN  = 2'b00;
  localparam logic [1:0] LAMP_YELLOW = 2'b01;
  localparam logic [1:0] LAMP_RED    = 2'b10;
  localparam logic [1:0] LAMP_OFF    = 2'b11;

  // Timer values marking the last cycle of each timed interval.
  localparam logic [CNT_W-1:0] GMIN_LAST  = CNT_W'(GREEN_MIN - 1);
  localparam logic [CNT_W-1:0] GMAX_LAST  = CNT_W'(GREEN_MAX - 1);
  localparam logic [CNT_W-1:0] YEL_LAST   = CNT_W'(YELLOW_CYC - 1);
  localparam logic [CNT_W-1:0] AR_LAST    = CNT_W'(ALLRED_CYC - 1);
  localparam logic [CNT_W-1:0] FLASH_LAST = CNT_W'(FLASH_HALF - 1);
  localparam logic [DIR_W-1:0] LAST_DIR   = DIR_W'(N_DIR - 1);

  phase_t            state, state_nxt;
  logic [DIR_W-1:0]  dir, dir_nxt;
  logic [CNT_W-1:0]  timer, timer_nxt;
  logic              blink, blink_nxt;
  logic [N_DIR-1:0]  dir_mask;
  logic              cur_req;
  logic              other_req;
  logic              green_exit;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
  endfunction

  // Rotate the request vector so bit i is approach from+1+i; the lowest set
  // bit is the next approach in round-robin order (from itself comes last).
  // With no requests the offset stays 0, i.e. simply advance by one.
  function automatic logic [DIR_W-1:0] rr_pick(input logic [DIR_W-1:0] from,
                                               input logic [N_DIR-1:0] req);
    logic [2*N_DIR-1:0] rot;
    int off;
    int sum;
    rot = {req, req} >> (int'(from) + 1);
    off = 0;
    for (int i = N_DIR - 1; i >= 0; i--) begin
      if (rot[i]) off = i;
    end
    sum = int'(from) + 1 + off;
    if (sum >= N_DIR) sum = sum - N_DIR;
    return DIR_W'(sum);
  endfunction

  always_comb begin
    dir_mask  = {{(N_DIR-1){1'b0}}, 1'b1} << dir;
    cur_req   = |(T & dir_mask);
    other_req = |(T & ~dir_mask);
    green_exit = flash_en
              || (timer >= GMIN_LAST && !cur_req && other_req)
              || (timer >= GMAX_LAST && other_req);
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= PH_GREEN;
      dir   <= '0;
      timer <= '0;
      blink <= 1'b0;
    end else begin
      state <= state_nxt;
      dir   <= dir_nxt;
      timer <= timer_nxt;
      blink <= blink_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    dir_nxt   = dir;
    timer_nxt = sat_inc(timer);
    blink_nxt = blink;
    unique case (state)
      PH_GREEN: begin
        if (green_exit) begin
          state_nxt = PH_YELLOW;
          timer_nxt = '0;
        end
      end
      PH_YELLOW: begin
        if (timer >= YEL_LAST) begin
          state_nxt = PH_ALLRED;
          timer_nxt = '0;
        end
      end
      PH_ALLRED: begin
        if (timer >= AR_LAST) begin
          timer_nxt = '0;
          blink_nxt = 1'b0;
          if (flash_en) begin
            state_nxt = PH_FLASH;
          end else begin
            state_nxt = PH_GREEN;
            dir_nxt   = rr_pick(dir, T);
          end
        end
      end
      PH_FLASH: begin
        if (!flash_en) begin
          // Parking on the last approach makes the next green search start at 0.
          state_nxt = PH_ALLRED;
          dir_nxt   = LAST_DIR;
          timer_nxt = '0;
          blink_nxt = 1'b0;
        end else if (timer >= FLASH_LAST) begin
          timer_nxt = '0;
          blink_nxt = ~blink;
        end
      end
      default: begin
        state_nxt = PH_GREEN;
        timer_nxt = '0;
      end
    endcase
  end

  // Output decode from registered state only
  always_comb begin
    L = '0;
    for (int i = 0; i < N_DIR; i++) begin
      unique case (state)
        PH_GREEN:  L[2*i +: 2] = (dir == DIR_W'(i)) ? LAMP_GREEN : LAMP_RED;
        PH_YELLOW: L[2*i +: 2] = (dir == DIR_W'(i)) ? LAMP_YELLOW : LAMP_RED;
        PH_ALLRED: L[2*i +: 2] = LAMP_RED;
        PH_FLASH:  L[2*i +: 2] = blink ? LAMP_YELLOW : LAMP_OFF;
        default:   L[2*i +: 2] = LAMP_RED;
      endcase
    end
  end

  assign cur_dir = dir;
  assign phase   = state;

endmodule

// File: tb/tb_tl_cntr_nway.sv
// Bench for tl_cntr_nway: directed scenarios with literal expectations plus a
// randomized run, all checked every cycle against a cycle-count behavioural model.
module tb_tl_cntr_nway;
  localparam int N_DIR      = 4;
  localparam int GREEN_MIN  = 4;
  localparam int GREEN_MAX  = 10;
  localparam int YELLOW_CYC = 2;
  localparam int ALLRED_CYC = 1;
  localparam int FLASH_HALF = 3;
  localparam int CNT_W      = 8;
  localparam int DIR_W      = 2;

  logic             clk = 1'b0;
  logic             reset;
  logic [N_DIR-1:0] T;
  logic             flash_en;
  logic [2*N_DIR-1:0] L;
  logic [DIR_W-1:0] cur_dir;
  logic [1:0]       phase;

  int  vectors = 0;
  int  miscompares = 0;
  bit  chk_on = 1'b0;

  // Model: phase, owning approach, and number of cycles shown so far in phase.
  int m_ph = 0;
  int m_dir = 0;
  int m_len = 1;

  tl_cntr_nway #(
    .N_DIR(N_DIR), .GREEN_MIN(GREEN_MIN), .GREEN_MAX(GREEN_MAX),
    .YELLOW_CYC(YELLOW_CYC), .ALLRED_CYC(ALLRED_CYC), .FLASH_HALF(FLASH_HALF),
    .CNT_W(CNT_W), .DIR_W(DIR_W)
  ) dut (
    .clk(clk), .reset(reset), .T(T), .flash_en(flash_en),
    .L(L), .cur_dir(cur_dir), .phase(phase)
  );

  always #5 clk = ~clk;

  function automatic bit req_at(input int j);
    return ((T >> j) & 4'd1) != 4'd0;
  endfunction

  function automatic int next_rr(input int from);
    for (int k = 1; k <= N_DIR; k++) begin
      if (req_at((from + k) % N_DIR)) return (from + k) % N_DIR;
    end
    return (from + 1) % N_DIR;
  endfunction

  task automatic model_step();
    int  nph;
    int  ndir;
    bit  other;
    if (reset) begin
      m_ph = 0; m_dir = 0; m_len = 1;
      return;
    end
    nph = m_ph; ndir = m_dir; other = 1'b0;
    for (int j = 0; j < N_DIR; j++) if (j != m_dir && req_at(j)) other = 1'b1;
    case (m_ph)
      0: if (flash_en || (m_len >= GREEN_MIN && !req_at(m_dir) && other)
             || (m_len >= GREEN_MAX && other)) nph = 1;
      1: if (m_len >= YELLOW_CYC) nph = 2;
      2: if (m_len >= ALLRED_CYC) begin
           if (flash_en) nph = 3;
           else begin nph = 0; ndir = next_rr(m_dir); end
         end
      default: if (!flash_en) begin nph = 2; ndir = N_DIR - 1; end
    endcase
    m_len = (nph != m_ph) ? 1 : m_len + 1;
    m_ph  = nph;
    m_dir = ndir;
  endtask

  function automatic logic [2*N_DIR-1:0] exp_lamps();
    logic [2*N_DIR-1:0] v;
    v = '0;
    for (int i = 0; i < N_DIR; i++) begin
      case (m_ph)
        0: v[2*i +: 2] = (i == m_dir) ? 2'b00 : 2'b10;
        1: v[2*i +: 2] = (i == m_dir) ? 2'b01 : 2'b10;
        2: v[2*i +: 2] = 2'b10;
        default: v[2*i +: 2] = (((m_len - 1) / FLASH_HALF) % 2 == 1) ? 2'b01 : 2'b11;
      endcase
    end
    return v;
  endfunction

  // Per-cycle comparison against the model, plus the no-dual-green rule.
  always @(negedge clk) begin
    logic [2*N_DIR-1:0] el;
    int nonred;
    if (chk_on) begin
      el = exp_lamps();
      vectors++;
      if (L !== el || phase !== 2'(m_ph) || cur_dir !== 2'(m_dir)) begin
        miscompares++;
        $display("FAIL model_cmp t=%0t L=%b want=%b phase=%0d want=%0d dir=%0d want=%0d",
                 $time, L, el, phase, m_ph, cur_dir, m_dir);
      end
      if (phase != 2'b11) begin
        nonred = 0;
        for (int i = 0; i < N_DIR; i++) if (L[2*i +: 2] != 2'b10) nonred++;
        vectors++;
        if (nonred != 1 && !(phase == 2'b10 && nonred == 0)) begin
          miscompares++;
          $display("FAIL lamp_exclusive t=%0t nonred=%0d phase=%0d L=%b", $time, nonred, phase, L);
        end
      end
    end
  end

  task automatic step(input logic [N_DIR-1:0] t, input logic f, input logic r);
    T = t; flash_en = f; reset = r;
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic lit(input string name, input int got, input int want);
    vectors++;
    if (got != want) begin
      miscompares++;
      $display("FAIL %s got=%0h want=%0h", name, got, want);
    end
  endtask

  task automatic run_until(input logic [N_DIR-1:0] t, input logic f, input int ph,
                           input int maxc, output int n);
    n = 0;
    while (int'(phase) != ph && n < maxc) begin
      step(t, f, 1'b0);
      n++;
    end
    vectors++;
    if (int'(phase) != ph) begin
      miscompares++;
      $display("FAIL timeout_phase%0d got=%0d want=%0d", ph, phase, ph);
    end
  endtask

  task automatic goto_dir2();
    int exp_ph [7] = '{0, 0, 0, 1, 1, 2, 0};
    int bad;
    bad = 0;
    step('0, 1'b0, 1'b1);
    for (int i = 0; i < 7; i++) begin
      step(4'b0100, 1'b0, 1'b0);
      if (int'(phase) != exp_ph[i]) bad++;
      if (i == 3 && L != 8'hA9) bad++;
      if (i == 5 && L != 8'hAA) bad++;
    end
    lit("s2_sequence", bad, 0);
    lit("s2_dir", int'(cur_dir), 2);
    lit("s2_lamps", int'(L), 'h8A);
  endtask

  initial begin
    int n;
    int bad;
    logic [N_DIR-1:0] rt;
    logic rf;
    chk_on = 1'b1;

    // Idle after reset: approach 0 green forever.
    step('0, 1'b0, 1'b1);
    lit("reset_lamps", int'(L), 'hA8);
    lit("reset_phase", int'(phase), 0);
    lit("reset_dir", int'(cur_dir), 0);
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      step('0, 1'b0, 1'b0);
      if (L != 8'hA8 || phase != 2'b00 || cur_dir != 2'd0) bad++;
    end
    lit("idle_hold", bad, 0);

    // Minimum green then round-robin to 3 (T=1011) and wrap to 0 (T=0011).
    goto_dir2();
    run_until(4'b1011, 1'b0, 2, 30, n);
    step(4'b1011, 1'b0, 1'b0);
    lit("rr_next3", int'(cur_dir), 3);
    goto_dir2();
    run_until(4'b0011, 1'b0, 2, 30, n);
    step(4'b0011, 1'b0, 1'b0);
    lit("rr_wrap0", int'(cur_dir), 0);

    // Maximum green with both 0 and 1 busy.
    step('0, 1'b0, 1'b1);
    run_until(4'b0011, 1'b0, 1, 40, n);
    lit("gmax_len0", n, 10);
    run_until(4'b0011, 1'b0, 0, 10, n);
    lit("clear_len", n, 3);
    lit("gmax_dir1", int'(cur_dir), 1);
    run_until(4'b0011, 1'b0, 1, 40, n);
    lit("gmax_len1", n, 10);
    run_until(4'b0011, 1'b0, 0, 10, n);
    lit("gmax_back0", int'(cur_dir), 0);

    // Flash entry from early green, blink pattern, and exit to approach 0.
    step('0, 1'b0, 1'b1);
    step('0, 1'b0, 1'b0);
    step('0, 1'b1, 1'b0);
    lit("flash_to_yellow", int'(phase), 1);
    bad = 0;
    step('0, 1'b1, 1'b0); if (phase != 2'b01) bad++;
    step('0, 1'b1, 1'b0); if (phase != 2'b10) bad++;
    step('0, 1'b1, 1'b0); if (phase != 2'b11) bad++;
    lit("flash_entry_seq", bad, 0);
    bad = 0;
    for (int i = 0; i < 12; i++) begin
      if (L != ((((i / 3) % 2) == 1) ? 8'h55 : 8'hFF)) bad++;
      step('0, 1'b1, 1'b0);
    end
    lit("flash_blink", bad, 0);
    step('0, 1'b0, 1'b0);
    lit("flash_exit_allred", int'(phase), 2);
    lit("flash_exit_dir", int'(cur_dir), 3);
    step('0, 1'b0, 1'b0);
    lit("flash_exit_green0", int'(cur_dir), 0);
    run_until('0, 1'b1, 3, 10, n);
    step(4'b0110, 1'b0, 1'b0);
    step(4'b0110, 1'b0, 1'b0);
    lit("flash_exit_lowest", int'(cur_dir), 1);

    // Reset in the middle of yellow.
    step('0, 1'b0, 1'b1);
    run_until(4'b1111, 1'b0, 1, 40, n);
    step(4'b1111, 1'b0, 1'b1);
    lit("midreset_phase", int'(phase), 0);
    lit("midreset_dir", int'(cur_dir), 0);
    lit("midreset_lamps", int'(L), 'hA8);
    run_until(4'b1111, 1'b0, 1, 40, n);
    lit("midreset_timer", n, 10);

    // Randomized traffic with occasional flash toggles and resets.
    rf = 1'b0;
    for (int c = 0; c < 4000; c++) begin
      for (int j = 0; j < N_DIR; j++) rt[j] = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 59) == 0) rf = ~rf;
      step(rt, rf, $urandom_range(0, 299) == 0);
    end

    chk_on = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
